// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-neuron datapath.
// Current and weight widths are fixed at 8-bit signed across all stages.
package snn_pkg;

    localparam int CUR_W      = 8;
    localparam int WEIGHT_W   = 8;
    localparam int I_SYN_MAX  = 127;
    localparam int I_SYN_MIN  = -128;
    localparam int V_SPIKE_TH = 50;
    localparam int V_RESET    = -20;

    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef logic signed [CUR_W-1:0]    cur_t;

endpackage

// File: rtl/syn_event_fifo.sv
// Circular event FIFO with a count register separating full from empty.
// Push is refused when full and pop is ignored when empty.
module syn_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only read while r_count marks them valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/synapse_current.sv
// Synaptic current stage: queued spike events add signed weights into a
// saturating accumulator that decays toward zero on every timestep tick.
module synapse_current
    import snn_pkg::*;
#(
    parameter int N_INPUTS    = 8,
    parameter int ADDR_W      = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int DECAY_SHIFT = 3,
    parameter int ACC_W       = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spk_valid,
    input  logic [ADDR_W-1:0] spk_addr,
    output logic              spk_ready,
    input  logic              tick,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic signed [7:0] wr_data,
    output logic signed [7:0] I_syn,
    output logic              busy,
    output logic              sat_flag
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] CUR_HI  = ACC_W'(I_SYN_MAX);
    localparam logic signed [ACC_W-1:0] CUR_LO  = ACC_W'(I_SYN_MIN);

    weight_t                   r_weight [N_INPUTS];
    logic signed [ACC_W-1:0]   r_acc;
    cur_t                      r_i_syn;
    logic                      r_sat;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic [ADDR_W-1:0]         w_head;
    weight_t                   w_weight_sel;
    logic signed [ACC_W-1:0]   w_decay;
    logic signed [ACC_W:0]     w_sum;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic                      w_acc_clamp;
    logic                      w_cur_hi;
    logic                      w_cur_lo;
    cur_t                      w_cur_next;

    assign spk_ready = !w_full;
    assign busy      = !w_empty;
    assign w_push    = spk_valid && spk_ready;
    assign w_pop     = !tick && !w_empty;

    syn_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (spk_addr),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Out-of-range addresses are accepted but weigh nothing.
    always_comb begin
        w_weight_sel = '0;
        if (int'(w_head) < N_INPUTS) w_weight_sel = r_weight[w_head];
    end

    assign w_decay = r_acc >>> DECAY_SHIFT;
    assign w_sum   = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_weight_sel);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_acc_next  = r_acc;
        w_acc_clamp = 1'b0;
        if (tick) begin
            // A positive residue below 2^DECAY_SHIFT would never shift away.
            if (r_acc > 0 && w_decay == '0) w_acc_next = r_acc - ACC_W'(1);
            else                            w_acc_next = r_acc - w_decay;
        end else if (w_pop) begin
            if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
                w_acc_clamp = 1'b1;
                w_acc_next  = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                w_acc_next  = w_sum[ACC_W-1:0];
            end
        end
    end

    assign w_cur_hi   = (r_acc > CUR_HI);
    assign w_cur_lo   = (r_acc < CUR_LO);
    assign w_cur_next = w_cur_hi ? cur_t'(I_SYN_MAX) :
                        w_cur_lo ? cur_t'(I_SYN_MIN) : cur_t'(r_acc);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // The weight table is reset because a cleared synapse must contribute nothing.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_acc   <= '0;
            r_i_syn <= '0;
            r_sat   <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) r_weight[i] <= '0;
        end else begin
            r_acc   <= w_acc_next;
            r_i_syn <= w_cur_next;
            if (w_acc_clamp || w_cur_hi || w_cur_lo) r_sat <= 1'b1;
            if (wr_en && int'(wr_addr) < N_INPUTS) r_weight[wr_addr] <= wr_data;
        end
    end

    assign I_syn    = r_i_syn;
    assign sat_flag = r_sat;

endmodule

// File: tb/tb_synapse_current.sv
// Self-checking bench for synapse_current: a queue/integer model checked every
// cycle, directed scenarios pinned with hand-computed values, then random traffic.
module tb_synapse_current;

    localparam int N_INPUTS = 8;
    localparam int DEPTH    = 4;
    localparam int DIV      = 8;   // 2^DECAY_SHIFT

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              spk_valid = 1'b0;
    logic [2:0]        spk_addr  = '0;
    logic              tick      = 1'b0;
    logic              wr_en     = 1'b0;
    logic [2:0]        wr_addr   = '0;
    logic signed [7:0] wr_data   = '0;
    logic              spk_ready;
    logic signed [7:0] I_syn;
    logic              busy;
    logic              sat_flag;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    int m_acc  = 0;
    int m_isyn = 0;
    bit m_sat  = 1'b0;
    int m_wt [N_INPUTS];
    int m_q  [$];

    synapse_current dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spk_valid (spk_valid),
        .spk_addr  (spk_addr),
        .spk_ready (spk_ready),
        .tick      (tick),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .I_syn     (I_syn),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Decay by floor(acc / 2^k); positive leftovers step down by one.
    function automatic int decayed(input int a);
        int d;
        d = (a >= 0) ? a / DIV : -((-a + DIV - 1) / DIV);
        if (a > 0 && d == 0) return a - 1;
        return a - d;
    endfunction

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_acc  = 0;
            m_isyn = 0;
            m_sat  = 1'b0;
            foreach (m_wt[i]) m_wt[i] = 0;
            m_q.delete();
        end else begin
            int  old_acc;
            int  sum;
            bit  do_pop;
            bit  do_push;
            old_acc = m_acc;
            do_push = spk_valid && (m_q.size() < DEPTH);
            do_pop  = !tick && (m_q.size() > 0);
            m_isyn  = clampi(old_acc, -128, 127);
            if (m_isyn != old_acc) m_sat = 1'b1;
            if (tick) begin
                m_acc = decayed(old_acc);
            end else if (do_pop) begin
                int a;
                a   = m_q.pop_front();
                sum = old_acc + ((a < N_INPUTS) ? m_wt[a] : 0);
                m_acc = clampi(sum, -2048, 2047);
                if (m_acc != sum) m_sat = 1'b1;
            end
            if (do_push) m_q.push_back(int'(spk_addr));
            if (wr_en) m_wt[wr_addr] = int'(wr_data);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("i_syn",     int'(I_syn),     m_isyn);
            check("spk_ready", int'(spk_ready), int'(m_q.size() < DEPTH));
            check("busy",      int'(busy),      int'(m_q.size() > 0));
            check("sat_flag",  int'(sat_flag),  int'(m_sat));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic wr(input int addr, input int data);
        wr_en = 1'b1; wr_addr = 3'(addr); wr_data = 8'(data);
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic ev(input int addr);
        spk_valid = 1'b1; spk_addr = 3'(addr);
        cyc(1);
        spk_valid = 1'b0;
    endtask

    task automatic decay_steps(input int start, input int e0, input int e1, input int e2);
        int exp_v [3];
        exp_v = '{e0, e1, e2};
        do_reset();
        wr(4, start);
        ev(4);
        cyc(2);
        check("preload_isyn", int'(I_syn), start);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; cyc(1);
            tick = 1'b0; cyc(1);
            check("decay_model", m_acc, exp_v[i]);
            check("decay_isyn", int'(I_syn), exp_v[i]);
        end
    endtask

    initial begin
        cyc(2);
        rst_n  = 1'b0;
        chk_on = 1'b1;
        check("rst_isyn",  int'(I_syn), 0);
        check("rst_ready", int'(spk_ready), 1);
        check("rst_busy",  int'(busy), 0);
        check("rst_sat",   int'(sat_flag), 0);

        // Single event latency
        wr(2, 10);
        ev(2);
        check("lat_busy_e0", int'(busy), 1);
        cyc(1);
        check("lat_acc_e1", m_acc, 10);
        check("lat_busy_e1", int'(busy), 0);
        cyc(1);
        check("lat_isyn_e2", int'(I_syn), 10);

        // Exponential decay, both signs
        decay_steps(64, 56, 49, 43);
        decay_steps(-64, -56, -49, -42);

        do_reset();
        wr(4, 5); ev(4); cyc(2);
        tick = 1'b1; cyc(4);
        check("res5_after4", m_acc, 1);
        cyc(1);
        check("res5_after5", m_acc, 0);
        tick = 1'b0; cyc(1);
        check("res5_isyn", int'(I_syn), 0);

        do_reset();
        wr(4, -5); ev(4); cyc(2);
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("resm5_step", m_acc, -4 + i);
        end
        tick = 1'b0; cyc(1);
        check("resm5_isyn", int'(I_syn), 0);

        // Back-pressure with pops stalled by tick
        do_reset();
        tick = 1'b1; spk_valid = 1'b1; spk_addr = 3'd6;
        cyc(6);
        check("bp_ready", int'(spk_ready), 0);
        check("bp_busy", int'(busy), 1);
        check("bp_depth", m_q.size(), 4);
        tick = 1'b0; spk_valid = 1'b0;
        cyc(3);
        check("bp_busy_3", int'(busy), 1);
        cyc(1);
        check("bp_busy_4", int'(busy), 0);
        check("bp_ready_4", int'(spk_ready), 1);

        // Positive saturation, 20 events of +127
        do_reset();
        wr(1, 127);
        spk_valid = 1'b1; spk_addr = 3'd1;
        cyc(3);
        check("sat_before", int'(sat_flag), 0);
        cyc(1);
        check("sat_isyn", int'(I_syn), 127);
        check("sat_set", int'(sat_flag), 1);
        cyc(13);
        check("sat_acc16", m_acc, 2032);
        cyc(1);
        check("sat_acc17", m_acc, 2047);
        cyc(2);
        spk_valid = 1'b0;
        cyc(2);
        check("sat_acc_end", m_acc, 2047);
        check("sat_isyn_end", int'(I_syn), 127);

        do_reset();
        wr(0, -128); ev(0); cyc(2);
        check("neg_isyn", int'(I_syn), -128);

        // Pop and weight write to the same address in one cycle
        do_reset();
        wr(3, 5);
        ev(3);
        wr(3, 40);
        check("rbw_old", m_acc, 5);
        ev(3);
        cyc(2);
        check("rbw_new_acc", m_acc, 45);
        check("rbw_new_isyn", int'(I_syn), 45);

        // Asynchronous reset with events queued
        do_reset();
        wr(5, 100);
        spk_valid = 1'b1; spk_addr = 3'd5;
        cyc(3);
        spk_valid = 1'b0;
        cyc(2);
        check("ar_acc", m_acc, 300);
        tick = 1'b1; spk_valid = 1'b1;
        cyc(3);
        spk_valid = 1'b0;
        check("ar_queued", m_q.size(), 3);
        check("ar_sat_before", int'(sat_flag), 1);
        #2 rst_n = 1'b1;
        #1;
        check("ar_isyn", int'(I_syn), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_ready", int'(spk_ready), 1);
        check("ar_sat", int'(sat_flag), 0);
        tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;

        // Random traffic, mostly small weights so the current stays in range
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 149) do_reset();
            spk_valid = ($urandom_range(0, 3) != 0);
            spk_addr  = 3'($urandom_range(0, 7));
            tick      = ($urandom_range(0, 9) == 0);
            wr_en     = ($urandom_range(0, 5) == 0);
            wr_addr   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) wr_data = 8'($urandom);
            else                           wr_data = 8'(int'($urandom_range(0, 40)) - 20);
            cyc(1);
        end
        spk_valid = 1'b0; tick = 1'b0; wr_en = 1'b0;
        cyc(8);
        check("drain_busy", int'(busy), 0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
